// File: rtl/maze_pkg.sv
// Shared types for the maze DFS controller: FSM states, directions, coordinates.
// REPLAY exists only when MAZE_DFS_REPLAY_EN is defined.
package maze_pkg;

    localparam int MAZE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CHECK,
        MOVE,
        BACK,
        DONE,
        FAIL
`ifdef MAZE_DFS_REPLAY_EN
        ,
        REPLAY
`endif
    } state_t;

    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_D = 2'd1;
    localparam logic [1:0] DIR_L = 2'd2;
    localparam logic [1:0] DIR_U = 2'd3;

    typedef struct packed {
        logic [MAZE_W-1:0] x;
        logic [MAZE_W-1:0] y;
    } coord_t;

    typedef struct packed {
        coord_t c;
        logic   oor;
    } nbr_t;

    // Wrapped neighbour plus a flag for stepping off the grid edge.
    function automatic nbr_t next_coord(coord_t c, logic [1:0] dir);
        nbr_t r;
        r.c   = c;
        r.oor = 1'b0;
        case (dir)
            DIR_R: begin r.c.x = c.x + 1'b1; r.oor = &c.x;        end
            DIR_D: begin r.c.y = c.y + 1'b1; r.oor = &c.y;        end
            DIR_L: begin r.c.x = c.x - 1'b1; r.oor = (c.x == '0); end
            default: begin r.c.y = c.y - 1'b1; r.oor = (c.y == '0); end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/maze_nbr_gen.sv
// Combinational neighbour/range generator for the current cell and direction.
module maze_nbr_gen
    import maze_pkg::*;
#(
    parameter int W = MAZE_W
) (
    input  logic [W-1:0] curX,
    input  logic [W-1:0] curY,
    input  logic [1:0]   dir,
    output logic [W-1:0] nbrX,
    output logic [W-1:0] nbrY,
    output logic         oor
);

    coord_t c;
    nbr_t   n;

    assign c.x  = curX;
    assign c.y  = curY;
    assign n    = next_coord(c, dir);
    assign nbrX = n.c.x;
    assign nbrY = n.c.y;
    assign oor  = n.oor;

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze search sequencer driving maze RAM and the coordinate stack.
// Optional path replay after the goal is enabled by MAZE_DFS_REPLAY_EN.
module maze_dfs_ctrl
    import maze_pkg::*;
#(
    parameter int W           = MAZE_W,
    parameter int GOAL_X      = 15,
    parameter int GOAL_Y      = 15,
    parameter int STACK_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] rdX,
    output logic [W-1:0] rdY,
    input  logic         rdWall,
    output logic         wrEn,
    output logic [W-1:0] wrX,
    output logic [W-1:0] wrY,
    output logic         push,
    output logic         pop,
    output logic [W-1:0] xIn,
    output logic [W-1:0] yIn,
    input  logic [W-1:0] xOut,
    input  logic [W-1:0] yOut,
    input  logic         stackFail,
    output logic [W-1:0] curX,
    output logic [W-1:0] curY,
    output logic         busy,
    output logic         done,
    output logic         fail
`ifdef MAZE_DFS_REPLAY_EN
    ,
    output logic         pathValid,
    output logic [W-1:0] pathX,
    output logic [W-1:0] pathY
`endif
);

    localparam int            DW        = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [W-1:0]  GX        = W'(GOAL_X);
    localparam logic [W-1:0]  GY        = W'(GOAL_Y);

    state_t        state, state_nx;
    logic [W-1:0]  cur_x_nx, cur_y_nx;
    logic [DW-1:0] depth, depth_nx;
    logic [1:0]    dir, dir_nx;
    logic [W-1:0]  nbr_x, nbr_y;
    logic          nbr_oor;
    logic          push_c, pop_c, wr_c;
    logic          at_goal;

    maze_nbr_gen #(.W(W)) u_nbr (
        .curX (curX),
        .curY (curY),
        .dir  (dir),
        .nbrX (nbr_x),
        .nbrY (nbr_y),
        .oor  (nbr_oor)
    );

    assign at_goal = (curX == GX) && (curY == GY);

    // Pulses are masked during reset so an aborted search never touches stack or RAM.
    assign push = push_c & ~rst;
    assign pop  = pop_c  & ~rst;
    assign wrEn = wr_c   & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            curX  <= '0;
            curY  <= '0;
            depth <= '0;
            dir   <= '0;
        end else begin
            state <= state_nx;
            curX  <= cur_x_nx;
            curY  <= cur_y_nx;
            depth <= depth_nx;
            dir   <= dir_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cur_x_nx = curX;
        cur_y_nx = curY;
        depth_nx = depth;
        dir_nx   = dir;
        push_c   = 1'b0;
        pop_c    = 1'b0;
        wr_c     = 1'b0;
        wrX      = '0;
        wrY      = '0;
        xIn      = '0;
        yIn      = '0;
        rdX      = '0;
        rdY      = '0;
        busy     = 1'b0;
        done     = (state == DONE);
        fail     = (state == FAIL);
`ifdef MAZE_DFS_REPLAY_EN
        pathValid = 1'b0;
        pathX     = '0;
        pathY     = '0;
`endif
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) state_nx = INIT;
            end
            INIT: begin
                busy     = 1'b1;
                wr_c     = 1'b1;
                cur_x_nx = '0;
                cur_y_nx = '0;
                depth_nx = '0;
                dir_nx   = DIR_R;
                state_nx = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                rdX  = nbr_x;
                rdY  = nbr_y;
                if (at_goal) begin
`ifdef MAZE_DFS_REPLAY_EN
                    state_nx = REPLAY;
`else
                    state_nx = DONE;
`endif
                end else if (!nbr_oor && !rdWall) begin
                    state_nx = MOVE;
                end else if (dir != DIR_U) begin
                    dir_nx = dir + 1'b1;
                end else begin
                    state_nx = BACK;
                end
            end
            MOVE: begin
                busy = 1'b1;
                if (depth == DEPTH_MAX) begin
                    state_nx = FAIL;
                end else begin
                    push_c   = 1'b1;
                    xIn      = curX;
                    yIn      = curY;
                    wr_c     = 1'b1;
                    wrX      = nbr_x;
                    wrY      = nbr_y;
                    cur_x_nx = nbr_x;
                    cur_y_nx = nbr_y;
                    depth_nx = depth + 1'b1;
                    dir_nx   = DIR_R;
                    state_nx = CHECK;
                end
            end
            BACK: begin
                busy = 1'b1;
                if (depth == '0) begin
                    state_nx = FAIL;
                end else begin
                    pop_c    = 1'b1;
                    cur_x_nx = xOut;
                    cur_y_nx = yOut;
                    depth_nx = depth - 1'b1;
                    dir_nx   = DIR_R;
                    state_nx = CHECK;
                end
            end
`ifdef MAZE_DFS_REPLAY_EN
            REPLAY: begin
                busy = 1'b1;
                if (depth == '0) begin
                    state_nx = DONE;
                end else begin
                    pop_c     = 1'b1;
                    pathValid = 1'b1;
                    pathX     = xOut;
                    pathY     = yOut;
                    depth_nx  = depth - 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
        if (busy && stackFail) state_nx = FAIL;
    end

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Scoreboard bench for maze_dfs_ctrl: two instances (stack depth 64 and 8) with RAM and stack models.
// Build with MAZE_DFS_REPLAY_EN defined to cover path replay as well.
module tb_maze_dfs_ctrl;

    localparam int W = 4;
    localparam logic [2:0] K_PUSH = 3'd0;
    localparam logic [2:0] K_POP  = 3'd1;
    localparam logic [2:0] K_DONE = 3'd2;
    localparam logic [2:0] K_FAIL = 3'd3;
    localparam logic [2:0] K_PATH = 3'd4;

    typedef struct packed {
        logic       inst;
        logic [2:0] kind;
        logic [3:0] x;
        logic [3:0] y;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start [2];
    logic         ld    [2];
    logic [255:0] pat   [2];

    logic [W-1:0] rdX [2], rdY [2], wrX [2], wrY [2], xIn [2], yIn [2];
    logic [W-1:0] xOut [2], yOut [2], curX [2], curY [2];
    logic         rdWall [2], wrEn [2], push [2], pop [2], stackFail [2];
    logic         busy [2], done [2], fail [2];
`ifdef MAZE_DFS_REPLAY_EN
    logic         pathValid [2];
    logic [W-1:0] pathX [2], pathY [2];
`endif

    ev_t exp_q [$];
    int  checks = 0;
    int  errors = 0;

    for (genvar g = 0; g < 2; g++) begin : env
        localparam int SD = (g == 0) ? 64 : 8;
        logic [255:0] mem;
        logic [3:0]   sx [64];
        logic [3:0]   sy [64];
        int           sp;

        maze_dfs_ctrl #(.W(W), .GOAL_X(15), .GOAL_Y(15), .STACK_DEPTH(SD)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .rdX       (rdX[g]),
            .rdY       (rdY[g]),
            .rdWall    (rdWall[g]),
            .wrEn      (wrEn[g]),
            .wrX       (wrX[g]),
            .wrY       (wrY[g]),
            .push      (push[g]),
            .pop       (pop[g]),
            .xIn       (xIn[g]),
            .yIn       (yIn[g]),
            .xOut      (xOut[g]),
            .yOut      (yOut[g]),
            .stackFail (stackFail[g]),
            .curX      (curX[g]),
            .curY      (curY[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .fail      (fail[g])
`ifdef MAZE_DFS_REPLAY_EN
            ,
            .pathValid (pathValid[g]),
            .pathX     (pathX[g]),
            .pathY     (pathY[g])
`endif
        );

        assign rdWall[g]    = mem[{rdY[g], rdX[g]}];
        assign xOut[g]      = (sp > 0) ? sx[6'(sp - 1)] : 4'd0;
        assign yOut[g]      = (sp > 0) ? sy[6'(sp - 1)] : 4'd0;
        assign stackFail[g] = 1'b0;

        always @(posedge clk) begin
            if (ld[g]) mem <= pat[g];
            else if (wrEn[g]) mem[{wrY[g], wrX[g]}] <= 1'b1;
            if (rst) begin
                sp <= 0;
            end else if (push[g] && sp < SD) begin
                sx[6'(sp)] <= xIn[g];
                sy[6'(sp)] <= yIn[g];
                sp <= sp + 1;
            end else if (pop[g] && sp > 0) begin
                sp <= sp - 1;
            end
        end
    end

    task automatic observe(input logic inst, input logic [2:0] kind, input logic [3:0] x, input logic [3:0] y);
        ev_t got;
        ev_t e;
        got.inst = inst; got.kind = kind; got.x = x; got.y = y;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got inst=%0d kind=%0d (%0d,%0d) required no event", inst, kind, x, y);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL event got inst=%0d kind=%0d (%0d,%0d) required inst=%0d kind=%0d (%0d,%0d)",
                         inst, kind, x, y, e.inst, e.kind, e.x, e.y);
            end
        end
    endtask

    logic done_q [2];
    logic fail_q [2];

    initial begin
        done_q[0] = 1'b0; done_q[1] = 1'b0;
        fail_q[0] = 1'b0; fail_q[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst) begin
                    if (push[i]) observe(i[0], K_PUSH, xIn[i], yIn[i]);
                    if (pop[i]) observe(i[0], K_POP, xOut[i], yOut[i]);
`ifdef MAZE_DFS_REPLAY_EN
                    if (pathValid[i]) observe(i[0], K_PATH, pathX[i], pathY[i]);
`endif
                    if (done[i] && !done_q[i]) observe(i[0], K_DONE, curX[i], curY[i]);
                    if (fail[i] && !fail_q[i]) observe(i[0], K_FAIL, curX[i], curY[i]);
                end
                done_q[i] = done[i];
                fail_q[i] = fail[i];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic inst, input logic [2:0] k, input int x, input int y);
        ev_t e;
        e.inst = inst; e.kind = k; e.x = 4'(x); e.y = 4'(y);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic load(input int i, input logic [255:0] p);
        @(negedge clk); pat[i] = p; ld[i] = 1'b1;
        @(negedge clk); ld[i] = 1'b0;
    endtask

    task automatic run(input int i, input int bound);
        int n;
        @(negedge clk); start[i] = 1'b1;
        @(negedge clk); start[i] = 1'b0;
        chk("busy_after_start", 64'(busy[i]), 64'd1);
        n = 0;
        while (!(done[i] || fail[i]) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL timeout inst=%0d waited %0d cycles required done or fail", i, n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Expected path on an open maze: right along row 0, then down column 15.
    task automatic exp_open(input int i);
        for (int x = 0; x < 15; x++) expect_ev(i[0], K_PUSH, x, 0);
        for (int y = 0; y < 15; y++) expect_ev(i[0], K_PUSH, 15, y);
`ifdef MAZE_DFS_REPLAY_EN
        for (int k = 29; k >= 0; k--) begin
            int px, py;
            px = (k < 15) ? k : 15;
            py = (k < 15) ? 0 : k - 15;
            expect_ev(i[0], K_POP, px, py);
            expect_ev(i[0], K_PATH, px, py);
        end
`endif
        expect_ev(i[0], K_DONE, 15, 15);
    endtask

    initial begin
        logic [255:0] p;
        int n;
        rst = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        ld[0] = 1'b0; ld[1] = 1'b0;
        pat[0] = '0; pat[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", 64'({push[0], pop[0], wrEn[0], busy[0], done[0], fail[0]}), 64'd0);
        chk("rst_pos", 64'({curX[0], curY[0], rdX[0], rdY[0], wrX[0], wrY[0], xIn[0], yIn[0]}), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Open maze
        load(0, '0);
        exp_open(0);
        run(0, 2000);
        chk("open_done", 64'({done[0], fail[0]}), 64'b10);
        chk("open_cur", 64'({curX[0], curY[0]}), 64'hFF);
        chk("open_visited", 64'($countones(env[0].mem)), 64'd31);
`ifdef MAZE_DFS_REPLAY_EN
        chk("open_stack", 64'(env[0].sp), 64'd0);
`else
        chk("open_stack", 64'(env[0].sp), 64'd30);
`endif

        // Boxed in at the start cell
        do_reset();
        p = '0; p[1] = 1'b1; p[16] = 1'b1;
        load(0, p);
        expect_ev(1'b0, K_FAIL, 0, 0);
        run(0, 100);
        chk("boxed_fail", 64'({done[0], fail[0]}), 64'b01);
        chk("boxed_stack", 64'(env[0].sp), 64'd0);

        // Dead-end corridor of three cells
        do_reset();
        p = '1; p[0] = 1'b0; p[1] = 1'b0; p[2] = 1'b0;
        load(0, p);
        expect_ev(1'b0, K_PUSH, 0, 0);
        expect_ev(1'b0, K_PUSH, 1, 0);
        expect_ev(1'b0, K_POP, 1, 0);
        expect_ev(1'b0, K_POP, 0, 0);
        expect_ev(1'b0, K_FAIL, 0, 0);
        run(0, 200);
        chk("dead_fail", 64'({done[0], fail[0]}), 64'b01);
        chk("dead_cur", 64'({curX[0], curY[0]}), 64'h00);

        // Reset during the first MOVE
        do_reset();
        load(0, '0);
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        n = 0;
        while (!push[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("move_reached", 64'(push[0]), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ctl", 64'({push[0], pop[0], wrEn[0], busy[0], done[0], fail[0]}), 64'd0);
        chk("midrst_pos", 64'({curX[0], curY[0], rdX[0], rdY[0], wrX[0], wrY[0], xIn[0], yIn[0]}), 64'd0);
        @(negedge clk); rst = 1'b0;
        load(0, '0);
        exp_open(0);
        run(0, 2000);
        chk("rerun_cur", 64'({curX[0], curY[0], done[0]}), 64'h1FF);

        // Depth limit of 8 on the second instance
        do_reset();
        load(1, '0);
        for (int x = 0; x < 8; x++) expect_ev(1'b1, K_PUSH, x, 0);
        expect_ev(1'b1, K_FAIL, 8, 0);
        run(1, 500);
        chk("limit_fail", 64'({done[1], fail[1]}), 64'b01);
        chk("limit_stack", 64'(env[1].sp), 64'd8);
        chk("limit_cur", 64'({curX[1], curY[1]}), 64'h80);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maze_dfs_ctrl.md
Name: maze_dfs_ctrl

Overview:
- Depth-first path-finding sequencer for the 16x16 maze. It drives the (x,y) coordinate stack through push/pop and walks maze memory one neighbour per cycle.
- It marks each visited cell in maze memory as a wall.
- It sits between the top-level start/done interface, the maze RAM and the coordinate stack, and is the only master of that stack.

Parameters:
- W, 4, coordinate width (grid is 2^W x 2^W).
- GOAL_X, 15, target column.
- GOAL_Y, 15, target row.
- STACK_DEPTH, 64, capacity of the attached stack. The controller never issues more pushes than this.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a search from (0,0).
- rdX  out  W  maze read column (neighbour under test).
- rdY  out  W  maze read row.
- rdWall  in  1  combinational read data; 1 = wall or visited, valid in the same cycle.
- wrEn  out  1  one-cycle pulse; marks cell (wrX,wrY) visited (writes 1).
- wrX  out  W  visited-mark column.
- wrY  out  W  visited-mark row.
- push  out  1  stack push pulse.
- pop  out  1  stack pop pulse.
- xIn  out  W  stack push data, column.
- yIn  out  W  stack push data, row.
- xOut  in  W  stack top, column; combinational, valid while the stack is non-empty.
- yOut  in  W  stack top, row.
- stackFail  in  1  stack over/underflow flag.
- curX  out  W  current position, column.
- curY  out  W  current position, row.
- busy  out  1  search in progress.
- done  out  1  goal reached; held until the next start.
- fail  out  1  no path or stack error; held until the next start.

Behaviour:
- Reset: state=IDLE. push, pop, wrEn, busy, done, fail, curX, curY, rdX, rdY, wrX, wrY, xIn, yIn and internal depth/dir counters all 0. Reset mid-search aborts immediately; no further stack or memory activity.
- States: IDLE, INIT, CHECK, MOVE, BACK, DONE, FAIL.
- IDLE/DONE/FAIL: start -> INIT. Clears done and fail, sets busy. start is ignored in all other states.
- INIT (1 cycle): cur=(0,0), wrEn at (0,0), depth=0, dir=0 -> CHECK.
- CHECK (1 cycle per direction), evaluated in priority order:
  - cur==(GOAL_X,GOAL_Y) -> DONE.
  - Otherwise dir selects the neighbour: 0=(x+1,y), 1=(x,y+1), 2=(x-1,y), 3=(x,y-1). rdX/rdY present that neighbour.
  - A neighbour outside 0..2^W-1 is treated as a wall; the read is still driven, with the wrapped value ignored.
  - Open neighbour (rdWall=0) -> MOVE.
  - Wall with dir<3 -> dir+1, stay in CHECK.
  - Wall with dir==3 -> BACK.
- MOVE (1 cycle):
  - If depth==STACK_DEPTH -> FAIL, with no push.
  - Otherwise push=1 with xIn/yIn=cur, wrEn=1 at the neighbour, cur<=neighbour, depth+1, dir=0 -> CHECK.
- BACK (1 cycle):
  - depth==0 -> FAIL (maze exhausted).
  - Otherwise pop=1, cur<=(xOut,yOut) sampled this cycle, depth-1, dir=0 -> CHECK.
  - Re-scanning from dir 0 is correct because visited cells read as walls.
- stackFail=1 in any busy state -> FAIL on the next edge.
- DONE/FAIL: busy=0; done or fail=1; cur holds its last position.
- Latency:
  - Goal at start: start -> done is 3 edges (INIT, CHECK, DONE).
  - Each forward step costs 1-4 CHECK cycles plus 1 MOVE.
  - Each backtrack costs 4 CHECK cycles plus 1 BACK.
- push, pop and wrEn are never asserted in the same cycle as each other, except the wrEn that accompanies push in MOVE.
- Visited marks persist in memory; the maze must be reloaded before a new search.

Optional Feature:
- Macro: MAZE_DFS_REPLAY_EN.
- With it:
  - Adds outputs pathValid (1 bit) and pathX/pathY (W bits each), plus a state REPLAY.
  - After the goal, DONE is deferred. REPLAY pops one entry per cycle, presenting (xOut,yOut) on pathX/pathY with pathValid=1, until depth==0.
  - Output order is goal-adjacent cell first, ending at (0,0). The goal cell itself is never on the stack.
  - done then asserts.
- Without it: those ports and the state are absent, and the stack is left holding the path.

Decomposition:
- Shared package maze_pkg holds:
  - the state enum;
  - direction constants DIR_R, DIR_D, DIR_L, DIR_U;
  - a coord struct {x,y};
  - function next_coord(coord, dir) returning {coord, out_of_range}.
- Natural sub-module: maze_nbr_gen, a combinational neighbour and range generator used by CHECK and MOVE.

Test Plan:
- Open maze (all rdWall=0 except visited cells): start -> 30 MOVEs along row 0 then column 15, done=1, curX/curY=15/15, depth 30, fail=0.
- Cell (1,0) and cell (0,1) walls: start -> INIT, 4 CHECKs, BACK with depth 0 -> fail=1, no push/pop ever seen.
- Dead-end corridor (0,0)->(1,0)->(2,0), all else walls: 2 pushes, then 2 pops, cur returns to (1,0) then (0,0), then fail=1.
- Open maze with STACK_DEPTH=8: push count reaches exactly 8, then fail=1 with no 9th push.
- rst pulsed during MOVE: next cycle all outputs 0, state IDLE. start then rescans from (0,0).
- MAZE_DFS_REPLAY_EN on the open maze: 30 pathValid beats; first beat (15,14), last beat (0,0); then done=1.
